fetch_responder: RTL and testbench
==================================

Name: fetch_responder

Overview:
- Serving end of the channel-unit fetch protocol. Answers the `request` pulses issued by the per-channel signal-storage unit.
- Reads a configured window of a source memory and presents one word at a time on `dataOut`, first-word-fall-through style.
- Each request pops the current word and prefetches the next one from the source memory.
- Sits between the shared source memory (BRAM read port) and one channel's `bramIn` data input.

Parameters:
- DEPTH, 256, number of words in the source memory. Address width is $clog2(DEPTH).
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 1, cycles from `memEn` high to valid `memData`. Legal range 1 to 4.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- baseAddr  in  $clog2(DEPTH)  first source address of the window
- numWords  in  $clog2(DEPTH)+1  number of words to serve; 0 is legal
- storeConfig  in  1  latch baseAddr/numWords when high; ignored unless state is IDLE or DONE
- start  in  1  begin serving the latched window
- stop  in  1  abort, return to IDLE
- request  in  1  pop request from the storage unit; rising-edge sensitive
- memAddr  out  $clog2(DEPTH)  source memory read address
- memEn  out  1  source memory read enable
- memData  in  DATA_WIDTH  source memory read data
- dataOut  out  DATA_WIDTH  current word presented to the storage unit
- dataValid  out  1  dataOut holds an unconsumed word
- busy  out  1  state is not IDLE and not DONE
- done  out  1  all numWords words have been popped
- overrun  out  1  sticky: a request edge arrived while dataValid was low during service

Behaviour:
- Reset (resetN low at a clock edge) forces state IDLE and clears all registers.
  - All outputs are 0, including dataOut, memAddr, memEn, dataValid, busy, done and overrun.
  - Reset takes effect mid-operation in the same way; no pending read survives.
- The request rising edge is detected internally: `reqEdge = request & ~request_q`, with request_q cleared on reset.
- States and transitions:
  - IDLE: on start, copy the latched base into `rdPtr`, clear `served`, clear overrun.
    - If latched numWords is 0, go to DONE; otherwise go to PREFETCH.
  - PREFETCH (1 cycle): memEn=1, memAddr=rdPtr. Go to WAIT.
  - WAIT (READ_LATENCY cycles, counted by latCnt): memEn=0.
    - On the last WAIT cycle, capture memData into dataOut.
    - Advance rdPtr; it wraps from DEPTH-1 to 0. Go to READY.
  - READY: dataValid=1. On reqEdge, increment `served` and clear dataValid next cycle.
    - If served+1 equals numWords, go to DONE; otherwise go to PREFETCH.
  - DONE: done=1, dataValid=0. On start, restart as from IDLE. On stop, go to IDLE.
- stop has priority over every other input in all non-IDLE states. Next state is IDLE and dataValid, done and busy drop next cycle. A read in flight is discarded.
- dataOut is not cleared on pop or stop. It holds the last captured word until the next capture or reset.
- Latency:
  - start sampled at cycle T gives memEn at T+1 and dataValid at T+READ_LATENCY+2.
  - reqEdge at cycle R gives the next dataValid at R+READ_LATENCY+2.
  - The storage unit's inter-request delay must be at least READ_LATENCY+2 cycles.
- A reqEdge outside READY (IDLE excluded) sets overrun and is otherwise ignored; it is not queued. overrun clears only on reset or on start.
- start while busy is ignored. storeConfig while busy is ignored.
- Simultaneous storeConfig and start in IDLE: the window starts with the old latched config. The new values take effect on the next start.
- served and numWords are both $clog2(DEPTH)+1 bits wide. numWords=DEPTH serves every word exactly once, wrapping as needed.

Test Plan:
- baseAddr=5, numWords=3, READ_LATENCY=1, memory holds word[i]=0xA000_0000+i; start, then pulse request 1 cycle whenever dataValid is high.
  - Required: dataOut values 0xA0000005, 0xA0000006, 0xA0000007, each appearing 3 cycles after the prior request.
  - Required: done=1 after the third pop; memEn pulses exactly 3 times.
- Wrap: DEPTH=256, baseAddr=254, numWords=4.
  - Required: memAddr sequence 254, 255, 0, 1; done asserted after 4 pops.
- numWords=0, start.
  - Required: DONE on the next cycle, memEn never asserted, dataValid stays 0.
- Request held high for 5 cycles in READY.
  - Required: exactly one pop.
  - Then a request pulse during WAIT: overrun=1, served unchanged, and the following READY still presents the correct next word.
- stop during WAIT of the second word.
  - Required: IDLE next cycle, busy=0, dataValid=0, no capture.
  - Required: restarting with start yields the first word again.
- resetN low for 1 cycle while in READY.
  - Required: all outputs 0 next cycle; a request afterwards does not set overrun.

Source files
------------

// File: rtl/fetch_responder.sv
// Serving end of the channel-unit fetch protocol: reads a configured window of a
// source memory and presents one word at a time on dataOut, first-word-fall-through.
module fetch_responder #(
    parameter int DEPTH        = 256,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [$clog2(DEPTH)-1:0]   baseAddr,
    input  logic [$clog2(DEPTH):0]     numWords,
    input  logic                       storeConfig,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       request,
    output logic [$clog2(DEPTH)-1:0]   memAddr,
    output logic                       memEn,
    input  logic [DATA_WIDTH-1:0]      memData,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       dataValid,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        WAIT,
        READY,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         base_q, base_d;
    logic [AW:0]           num_q, num_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           served_q, served_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overrun_q, overrun_d;
    logic                  request_q;

    logic                  req_edge;
    logic                  configurable;
    logic [AW:0]           served_inc;

    assign req_edge     = request & ~request_q;
    assign configurable = (state_q == IDLE) || (state_q == DONE);
    assign served_inc   = served_q + 1'b1;

    // NOTE: every variable is given a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        rd_ptr_d  = rd_ptr_q;
        served_d  = served_q;
        lat_cnt_d = lat_cnt_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        // start reads the registered config, so a simultaneous store lands next time
        if (storeConfig && configurable) begin
            base_d = baseAddr;
            num_d  = numWords;
        end

        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (req_edge && (state_q == DONE)) overrun_d = 1'b1;
                    if (start) begin
                        rd_ptr_d  = base_q;
                        served_d  = '0;
                        overrun_d = 1'b0;
                        state_d   = (num_q == '0) ? DONE : PREFETCH;
                    end
                end
                PREFETCH: begin
                    if (req_edge) overrun_d = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (req_edge) overrun_d = 1'b1;
                    if (lat_cnt_q == LAT_LAST) begin
                        data_d   = memData;
                        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                        state_d  = READY;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end
                READY: begin
                    if (req_edge) begin
                        served_d = served_inc;
                        state_d  = (served_inc == num_q) ? DONE : PREFETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            rd_ptr_q  <= '0;
            served_q  <= '0;
            lat_cnt_q <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            request_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            rd_ptr_q  <= rd_ptr_d;
            served_q  <= served_d;
            lat_cnt_q <= lat_cnt_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            request_q <= request;
        end
    end

    assign memEn     = (state_q == PREFETCH);
    assign memAddr   = rd_ptr_q;
    assign dataOut   = data_q;
    assign dataValid = (state_q == READY);
    assign busy      = !configurable;
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder: a cycle table for the basic window plus
// hand-written sequences for wrap, empty window, overrun, stop and reset.
module tb_fetch_responder;

    logic        clk = 1'b0;
    logic        resetN;
    logic [7:0]  baseAddr;
    logic [8:0]  numWords;
    logic        storeConfig, start, stop, request;
    logic [7:0]  memAddr;
    logic        memEn;
    logic [31:0] memData = '0;
    logic [31:0] dataOut;
    logic        dataValid, busy, done, overrun;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] addr_log[$];

    fetch_responder #(.DEPTH(256), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clk(clk), .resetN(resetN), .baseAddr(baseAddr), .numWords(numWords),
        .storeConfig(storeConfig), .start(start), .stop(stop), .request(request),
        .memAddr(memAddr), .memEn(memEn), .memData(memData), .dataOut(dataOut),
        .dataValid(dataValid), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Source memory: word[i] = 0xA000_0000 + i, one cycle read latency.
    always @(posedge clk) begin
        if (memEn === 1'b1) begin
            memData <= 32'hA000_0000 + {24'd0, memAddr};
            addr_log.push_back(memAddr);
        end
    end

    typedef struct {
        logic        store, strt, stp, req;
        logic [7:0]  base;
        logic [8:0]  num;
        logic        busy, done, dv, men;
        logic [7:0]  addr;
        logic [31:0] dout;
        logic        ovr;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && dataValid !== 1'b1; i++) tick();
        check(name, {63'd0, dataValid}, 64'd1);
    endtask

    initial begin
        resetN = 1'b0; baseAddr = '0; numWords = '0;
        storeConfig = 1'b0; start = 1'b0; stop = 1'b0; request = 1'b0;

        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 8'd5, 9'd3, 1'b0,1'b0,1'b0,1'b0, 8'd0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b1, 8'd5, 32'h0,         1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b0, 8'd5, 32'h0,         1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b1,1'b0, 8'd6, 32'hA000_0005, 1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b1, 8'd6, 32'hA000_0005, 1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b0, 8'd6, 32'hA000_0005, 1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b1,1'b0, 8'd7, 32'hA000_0006, 1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b1, 8'd7, 32'hA000_0006, 1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b0, 8'd7, 32'hA000_0006, 1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b1,1'b0,1'b1,1'b0, 8'd8, 32'hA000_0007, 1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1, 8'd0, 9'd0, 1'b0,1'b1,1'b0,1'b0, 8'd8, 32'hA000_0007, 1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0, 8'd0, 9'd0, 1'b0,1'b1,1'b0,1'b0, 8'd8, 32'hA000_0007, 1'b0};

        tick(); tick();
        check("rst.outputs", {dataOut, memAddr, memEn, dataValid, busy, done, overrun}, 64'd0);
        resetN = 1'b1;

        // Basic window: base 5, three words
        addr_log.delete();
        for (int i = 0; i < 12; i++) begin
            storeConfig = vecs[i].store; start = vecs[i].strt; stop = vecs[i].stp;
            request = vecs[i].req; baseAddr = vecs[i].base; numWords = vecs[i].num;
            tick();
            check($sformatf("v%0d.flags", i), {60'd0, busy, done, dataValid, memEn},
                  {60'd0, vecs[i].busy, vecs[i].done, vecs[i].dv, vecs[i].men});
            check($sformatf("v%0d.addr", i), {56'd0, memAddr}, {56'd0, vecs[i].addr});
            check($sformatf("v%0d.dout", i), {32'd0, dataOut}, {32'd0, vecs[i].dout});
            check($sformatf("v%0d.ovr", i), {63'd0, overrun}, {63'd0, vecs[i].ovr});
        end
        request = 1'b0;
        check("basic.en_count", 64'(addr_log.size()), 64'd3);

        // Wrap: base 254, four words
        storeConfig = 1'b1; baseAddr = 8'd254; numWords = 9'd4;
        tick();
        storeConfig = 1'b0;
        addr_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && done !== 1'b1; i++) begin
            request = (dataValid === 1'b1 && request == 1'b0);
            tick();
        end
        request = 1'b0;
        check("wrap.done", {63'd0, done}, 64'd1);
        check("wrap.en_count", 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            check("wrap.addr0", {56'd0, addr_log[0]}, 64'd254);
            check("wrap.addr1", {56'd0, addr_log[1]}, 64'd255);
            check("wrap.addr2", {56'd0, addr_log[2]}, 64'd0);
            check("wrap.addr3", {56'd0, addr_log[3]}, 64'd1);
        end
        check("wrap.last_word", {32'd0, dataOut}, 64'hA000_0001);

        // Empty window from IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_done.idle", {61'd0, busy, done, dataValid}, 64'd0);
        storeConfig = 1'b1; baseAddr = 8'd40; numWords = 9'd0;
        tick();
        storeConfig = 1'b0;
        addr_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty.done_next", {61'd0, done, busy, memEn}, 64'b100);
        tick(); tick(); tick();
        check("empty.no_read", 64'(addr_log.size()), 64'd0);
        check("empty.no_valid", {62'd0, dataValid, done}, 64'b01);

        // Held request pops once; a request edge during WAIT only flags overrun
        stop = 1'b1;
        tick();
        stop = 1'b0;
        storeConfig = 1'b1; baseAddr = 8'd10; numWords = 9'd3;
        tick();
        storeConfig = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("hold.first_valid");
        check("hold.first_word", {32'd0, dataOut}, 64'hA000_000A);
        request = 1'b1;
        repeat (5) tick();
        check("hold.one_pop", {30'd0, dataOut, dataValid, done}, {30'd0, 32'hA000_000B, 2'b10});
        check("hold.no_ovr", {63'd0, overrun}, 64'd0);
        request = 1'b0; tick();
        request = 1'b1; tick();
        request = 1'b0; tick();
        request = 1'b1; tick();
        request = 1'b0;
        check("ovr.set", {63'd0, overrun}, 64'd1);
        check("ovr.next_word", {31'd0, dataOut, dataValid}, {31'd0, 32'hA000_000C, 1'b1});
        tick();
        request = 1'b1; tick();
        request = 1'b0;
        check("ovr.served_kept", {62'd0, done, overrun}, 64'b11);

        // Stop during WAIT of the second word, then restart
        storeConfig = 1'b1; baseAddr = 8'd20; numWords = 9'd3;
        tick();
        storeConfig = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart.ovr_clear", {55'd0, overrun, memEn, memAddr}, {55'd0, 1'b0, 1'b1, 8'd20});
        tick(); tick();
        check("stop.first_word", {31'd0, dataOut, dataValid}, {31'd0, 32'hA000_0014, 1'b1});
        request = 1'b1; tick();
        request = 1'b0; tick();
        stop = 1'b1; tick();
        stop = 1'b0;
        check("stop.idle", {29'd0, dataOut, busy, dataValid, done}, {29'd0, 32'hA000_0014, 3'b000});
        tick();
        check("stop.no_capture", {32'd0, dataOut}, 64'hA000_0014);

        // Simultaneous store and start: window runs on the old config
        storeConfig = 1'b1; baseAddr = 8'd50; numWords = 9'd1; start = 1'b1;
        tick();
        storeConfig = 1'b0; start = 1'b0;
        check("store_start.old_base", {55'd0, memEn, memAddr}, {55'd0, 1'b1, 8'd20});
        tick(); tick();
        check("restart.first_word", {31'd0, dataOut, dataValid}, {31'd0, 32'hA000_0014, 1'b1});

        // Reset while READY
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check("rst_ready.outputs", {dataOut, memAddr, memEn, dataValid, busy, done, overrun}, 64'd0);
        request = 1'b1; tick();
        request = 1'b0; tick();
        check("rst_ready.no_ovr", {62'd0, overrun, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
